// File: rtl/aes_cbc_decrypt_ctrl.sv
// aes_cbc_decrypt_ctrl: sequences one ciphertext block at a time through an
// AES decipher engine and returns the plaintext on a registered valid/ready port.
// Build option AES_CBC_CHAIN_EN: when defined, the engine result is XORed with
// the CBC chaining value (loaded from iv, then updated with each ciphertext);
// when undefined the block is a plain ECB passthrough and iv/iv_load are unused.
`timescale 1ns/1ps

module aes_cbc_decrypt_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [127:0] ct_data,
  input  logic         ct_last,
  output logic         dec_next,
  output logic [127:0] dec_block,
  input  logic         dec_ready,
  input  logic [127:0] dec_result,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [127:0] pt_data,
  output logic         pt_last,
  output logic         busy
);

  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   ct_q, ct_d;
  logic               last_q, last_d;
  logic [BLK_W-1:0]   pt_data_q, pt_data_d;
  logic               pt_last_q, pt_last_d;
  logic               pt_valid_q, pt_valid_d;
  logic               dec_next_q, dec_next_d;
  logic               busy_q, busy_d;
  logic               ct_ready_c;

`ifdef AES_CBC_CHAIN_EN
  logic [BLK_W-1:0]   chain_q, chain_d;
`else
  logic               unused_iv;
  assign unused_iv = ^{iv_load, iv};
`endif

  // State and datapath registers; async clear on reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ct_q       <= '0;
      last_q     <= 1'b0;
      pt_data_q  <= '0;
      pt_last_q  <= 1'b0;
      pt_valid_q <= 1'b0;
      dec_next_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef AES_CBC_CHAIN_EN
      chain_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ct_q       <= ct_d;
      last_q     <= last_d;
      pt_data_q  <= pt_data_d;
      pt_last_q  <= pt_last_d;
      pt_valid_q <= pt_valid_d;
      dec_next_q <= dec_next_d;
      busy_q     <= busy_d;
`ifdef AES_CBC_CHAIN_EN
      chain_q    <= chain_d;
`endif
    end
  end

  // Next-state, datapath updates and the combinational ciphertext ready
  always_comb begin
    state_d    = state_q;
    ct_d       = ct_q;
    last_d     = last_q;
    pt_data_d  = pt_data_q;
    pt_last_d  = pt_last_q;
    pt_valid_d = pt_valid_q;
    ct_ready_c = 1'b0;
`ifdef AES_CBC_CHAIN_EN
    chain_d    = chain_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef AES_CBC_CHAIN_EN
        // IV load wins over a pending ciphertext block
        ct_ready_c = !iv_load;
        if (iv_load) begin
          chain_d = iv;
        end else if (ct_valid) begin
          ct_d    = ct_data;
          last_d  = ct_last;
          state_d = S_START;
        end
`else
        ct_ready_c = 1'b1;
        if (ct_valid) begin
          ct_d    = ct_data;
          last_d  = ct_last;
          state_d = S_START;
        end
`endif
      end
      S_START: begin
        // dec_ready is not looked at here; the engine drops it on the leaving edge
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dec_ready) begin
`ifdef AES_CBC_CHAIN_EN
          pt_data_d = dec_result ^ chain_q;
          chain_d   = ct_q;
`else
          pt_data_d = dec_result;
`endif
          pt_last_d  = last_q;
          pt_valid_d = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (pt_ready) begin
          pt_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        pt_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    dec_next_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
  end

  assign ct_ready  = ct_ready_c;
  assign dec_next  = dec_next_q;
  assign dec_block = ct_q;
  assign pt_valid  = pt_valid_q;
  assign pt_data   = pt_data_q;
  assign pt_last   = pt_last_q;
  assign busy      = busy_q;

endmodule
